// File: rtl/dmem_ldst_responder_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_ldst_responder_pkg : shared ldst request/response packet types   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package dmem_ldst_responder_pkg;

    localparam int RV_XLEN     = 32;
    localparam int LDST_STRB_W = 4;

    typedef struct packed {
        logic [RV_XLEN-1:0]     addr;
        logic                   st;
        logic [RV_XLEN-1:0]     data;
        logic [LDST_STRB_W-1:0] strobe;
    } ldst_req_pkt_t;

    typedef struct packed {
        logic [RV_XLEN-1:0] data;
    } ldst_rsp_pkt_t;

endpackage
`default_nettype wire

// File: rtl/dmem_ldst_responder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ldst_req_if_t / ldst_rsp_if_t : valid/ready ldst request and response |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface ldst_req_if_t;
    import dmem_ldst_responder_pkg::*;
    logic          vld;
    logic          rdy;
    ldst_req_pkt_t pkt;
    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface

interface ldst_rsp_if_t;
    import dmem_ldst_responder_pkg::*;
    logic          vld;
    logic          rdy;
    ldst_rsp_pkt_t pkt;
    modport mst (output vld, output pkt, input rdy);
    modport slv (input vld, input pkt, output rdy);
endinterface
`default_nettype wire

// File: rtl/dmem_ldst_responder_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | ldst_rsp_fifo : flopped response buffer with push/pop/full/empty/count|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module ldst_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    import dmem_ldst_responder_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign count     = r_count;
    assign pop_data  = r_mem[r_rptr];
    assign w_do_pop  = pop & ~empty;
    // A push into a full buffer is accepted only when the head leaves this cycle.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_do_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_ldst_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_ldst_responder : aligns ldst requests onto a sync data SRAM      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module dmem_ldst_responder
    import dmem_ldst_responder_pkg::*;
#(
    parameter int SRAM_AW   = 12,
    parameter int RSP_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    ldst_req_if_t.slv              ldst_req_slv,
    ldst_rsp_if_t.mst              ldst_rsp_mst,
    output logic                   sram_cs,
    output logic                   sram_we,
    output logic [SRAM_AW-1:0]     sram_addr,
    output logic [LDST_STRB_W-1:0] sram_wstrb,
    output logic [RV_XLEN-1:0]     sram_wdata,
    input  logic [RV_XLEN-1:0]     sram_rdata
);

    localparam int CNT_W = $clog2(RSP_DEPTH+1);

    logic               w_hsk;
    logic               w_pop;
    logic [1:0]         w_off;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W:0]     w_occ;
    logic               w_empty;
    logic               w_fifo_full_unused;
    logic               w_unused_addr;
    logic [RV_XLEN-1:0] w_push_data;
    logic [RV_XLEN-1:0] w_head;

    logic               r_if_vld;
    logic               r_if_st;
    logic [1:0]         r_if_off;

    assign w_off         = ldst_req_slv.pkt.addr[1:0];
    assign w_unused_addr = ^ldst_req_slv.pkt.addr[RV_XLEN-1:SRAM_AW+2];

    // Credit check counts the head leaving this cycle so rdy=1 sustains full rate.
    assign w_pop = ldst_rsp_mst.vld & ldst_rsp_mst.rdy;
    assign w_occ = {1'b0, w_count} + {{CNT_W{1'b0}}, r_if_vld} - {{CNT_W{1'b0}}, w_pop};
    assign ldst_req_slv.rdy = ~rst & (w_occ < (CNT_W+1)'(RSP_DEPTH));

    assign w_hsk      = ldst_req_slv.vld & ldst_req_slv.rdy;
    assign sram_cs    = w_hsk & ~rst;
    assign sram_we    = sram_cs & ldst_req_slv.pkt.st;
    assign sram_addr  = ldst_req_slv.pkt.addr[SRAM_AW+1:2];
    assign sram_wdata = ldst_req_slv.pkt.data << {w_off, 3'b000};
    assign sram_wstrb = sram_we ? (ldst_req_slv.pkt.strobe << w_off) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_vld <= 1'b0;
            r_if_st  <= 1'b0;
            r_if_off <= 2'b00;
        end else begin
            r_if_vld <= w_hsk;
            if (w_hsk) begin
                r_if_st  <= ldst_req_slv.pkt.st;
                r_if_off <= w_off;
            end
        end
    end

    assign w_push_data = r_if_st ? '0 : (sram_rdata >> {r_if_off, 3'b000});

    ldst_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (RV_XLEN)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_if_vld),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full_unused),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign ldst_rsp_mst.vld      = ~w_empty;
    assign ldst_rsp_mst.pkt.data = w_head;

endmodule
`default_nettype wire
